serial_sub: RTL



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_sub_full_sub.sv | 14 +
 rtl/serial_sub.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default
// operand width and the bit-counter sizing helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must index WIDTH bit positions; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Combinational one-bit full subtractor: x - y - bi gives difference d and
// borrow-out bo.
module serial_sub_full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: resolves a - b - bin one bit per
// clock, LSB first, through a registered borrow, then pulses done.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-2:0] dreg_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             start_ok_s;
    logic             last_s;
    logic             d_s;
    logic             bo_s;
    logic [WIDTH-1:0] cat_s;

    serial_sub_full_sub u_full_sub (
        .x  (sa_r[0]),
        .y  (sb_r[0]),
        .bi (borrow_r),
        .d  (d_s),
        .bo (bo_s)
    );

    // New work is accepted only when idle or in the result cycle.
    assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    assign last_s     = (state_r == S_SHIFT) && (cnt_r == CW'(WIDTH - 1));
    // Full result: the bit being resolved now on top of the WIDTH-1 earlier bits.
    assign cat_s      = {d_s, dreg_r};

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_SHIFT;
                else       state_s = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt_r == CW'(WIDTH - 1)) state_s = S_DONE;
                else                         state_s = S_SHIFT;
            end
            S_DONE: begin
                if (start) state_s = S_SHIFT;
                else       state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_SHIFT);
            done_r  <= (state_s == S_DONE);
        end
    end

    // Operand shift registers, borrow chain and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r     <= '0;
            sb_r     <= '0;
            dreg_r   <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
        end else if (start_ok_s) begin
            sa_r     <= a;
            sb_r     <= b;
            dreg_r   <= '0;
            borrow_r <= bin;
            cnt_r    <= '0;
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
        end else if (state_r == S_SHIFT) begin
            sa_r     <= sa_r >> 1;
            sb_r     <= sb_r >> 1;
            dreg_r   <= cat_s[WIDTH-1:1];
            borrow_r <= bo_s;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    // Result registers: cleared on acceptance, loaded on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (start_ok_s) begin
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_s) begin
            diff_r <= cat_s;
            bout_r <= bo_s;
            ovf_r  <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;
    assign ovf  = ovf_r;

endmodule
